// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle multiply
// sequencing, data-miss stalls, branch flush and operand bypass selection.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; load-use bubbles inserted here
// MUL_WAIT | multiply occupying execute, cnt counts remaining stall cycles
// MEM_WAIT | data-memory miss outstanding, whole pipe frozen
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeRegE,
  input  logic [4:0]  writeRegM,
  input  logic [4:0]  writeRegW,
  input  logic        regWriteE,
  input  logic        regWriteM,
  input  logic        regWriteW,
  input  logic        memToRegE,
  input  logic        mulStartE,
  input  logic        pcSrcD,
  input  logic        dmissM,
  input  logic        dreadyM,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushD,
  output logic        flushE,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        mulDoneE,
  output logic        busy,
  output logic [31:0] stallCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // The cycle that launches the multiply is itself a stall cycle, so the
  // counter starts one below the latency.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q;

  logic mem_wait;
  logic load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_e;
  logic mul_done;

  // Hazard conditions derived directly from the pipeline inputs.
  always_comb begin
    mem_wait = dmissM & ~dreadyM;
    load_use = memToRegE & regWriteE & (writeRegE != 5'd0) &
               ((writeRegE == rsD) | (writeRegE == rtD));
  end

  // Next-state and stall/flush decode; outputs depend on the current inputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_e  = 1'b0;
    mul_done = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          state_d = MEM_WAIT;
        end else if (mulStartE) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          cnt_d   = MUL_CNT_INIT;
          state_d = MUL_WAIT;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (cnt_q != 4'd0) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = mem_wait;
          cnt_d   = cnt_q - 4'd1;
        end else if (mem_wait) begin
          // Result is ready but the memory stage is blocked: hold it back.
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
        end else begin
          mul_done = 1'b1;
          state_d  = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Operand bypass: memory stage result is newer, so it wins over writeback.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regWriteM && (writeRegM != 5'd0) && (writeRegM == rsE)) begin
      forwardAE = 2'b10;
    end else if (regWriteW && (writeRegW != 5'd0) && (writeRegW == rsE)) begin
      forwardAE = 2'b01;
    end
    if (regWriteM && (writeRegM != 5'd0) && (writeRegM == rtE)) begin
      forwardBE = 2'b10;
    end else if (regWriteW && (writeRegW != 5'd0) && (writeRegW == rtE)) begin
      forwardBE = 2'b01;
    end
  end

  // State, multiply counter and saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_f && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stallF     = stall_f;
  assign stallD     = stall_d;
  assign stallE     = stall_e;
  assign stallM     = stall_m;
  // A stalled decode stage keeps its instruction, so it must not be flushed.
  assign flushD     = pcSrcD & ~stall_d;
  assign flushE     = flush_e;
  assign mulDoneE   = mul_done;
  assign busy       = (state_q != RUN);
  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios followed by random
// traffic, with expected outputs queued by a reference model and checked
// by an independent monitor on the falling edge.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rsD = '0, rtD = '0, rsE = '0, rtE = '0;
  logic [4:0]  writeRegE = '0, writeRegM = '0, writeRegW = '0;
  logic        regWriteE = 1'b0, regWriteM = 1'b0, regWriteW = 1'b0;
  logic        memToRegE = 1'b0, mulStartE = 1'b0, pcSrcD = 1'b0;
  logic        dmissM = 1'b0, dreadyM = 1'b0;
  logic        stallF, stallD, stallE, stallM, flushD, flushE;
  logic [1:0]  forwardAE, forwardBE;
  logic        mulDoneE, busy;
  logic [31:0] stallCount;

  hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .mulStartE(mulStartE), .pcSrcD(pcSrcD),
    .dmissM(dmissM), .dreadyM(dreadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mulDoneE(mulDoneE), .busy(busy), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, w_e, w_m, w_w;
    logic       rw_e, rw_m, rw_w, load, mul, br, miss, rdy;
  } vec_t;

  typedef struct {
    logic [3:0]  stalls;  // {F,D,E,M}
    logic        fl_d, fl_e, done, bsy;
    logic [1:0]  fa, fb;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model: a multiply owes a number of further stall cycles, a
  // miss freezes everything until data returns, and stall cycles are tallied.
  bit     m_in_mul  = 1'b0;
  int     m_owed    = 0;
  bit     m_in_miss = 1'b0;
  longint m_stalls  = 0;

  function automatic logic [1:0] bypass(input logic [4:0] src, input vec_t v);
    if (v.rw_m && v.w_m != 0 && v.w_m == src) return 2'b10;
    if (v.rw_w && v.w_w != 0 && v.w_w == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic vec_t nop();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    bit   miss_wait, lu, freeze;
    @(posedge clk);
    #1;
    reset = v.rst; rsD = v.rs_d; rtD = v.rt_d; rsE = v.rs_e; rtE = v.rt_e;
    writeRegE = v.w_e; writeRegM = v.w_m; writeRegW = v.w_w;
    regWriteE = v.rw_e; regWriteM = v.rw_m; regWriteW = v.rw_w;
    memToRegE = v.load; mulStartE = v.mul; pcSrcD = v.br;
    dmissM = v.miss; dreadyM = v.rdy;
    if (v.rst) begin
      m_in_mul = 0; m_owed = 0; m_in_miss = 0; m_stalls = 0;
    end
    miss_wait = v.miss && !v.rdy;
    lu = v.load && v.rw_e && v.w_e != 0 && (v.w_e == v.rs_d || v.w_e == v.rt_d);
    freeze = 0;
    e = '{default: 0};
    e.bsy = m_in_mul || m_in_miss;
    e.cnt = 32'(m_stalls);
    if (m_in_miss) begin
      if (miss_wait) freeze = 1;
      else m_in_miss = 0;
    end else if (m_in_mul) begin
      if (m_owed > 0) begin
        e.stalls = {3'b111, miss_wait};
        m_owed--;
      end else if (miss_wait) begin
        freeze = 1;
      end else begin
        e.done = 1;
        m_in_mul = 0;
      end
    end else if (miss_wait) begin
      freeze = 1;
      m_in_miss = 1;
    end else if (v.mul) begin
      e.stalls = 4'b1110;
      m_in_mul = 1;
      m_owed = MUL_LAT - 1;
    end else if (lu) begin
      e.stalls = 4'b1100;
      e.fl_e = 1;
    end
    if (freeze) e.stalls = 4'b1111;
    e.fl_d = v.br && !e.stalls[2];
    e.fa = bypass(v.rs_e, v);
    e.fb = bypass(v.rt_e, v);
    if (e.stalls[3] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (v.rst) begin
      m_in_mul = 0; m_owed = 0; m_in_miss = 0; m_stalls = 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the combinational outputs are valid mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("stalls", 32'({stallF, stallD, stallE, stallM}), 32'(mon_e.stalls));
      check("flushD", 32'(flushD), 32'(mon_e.fl_d));
      check("flushE", 32'(flushE), 32'(mon_e.fl_e));
      check("mulDoneE", 32'(mulDoneE), 32'(mon_e.done));
      check("busy", 32'(busy), 32'(mon_e.bsy));
      check("forwardAE", 32'(forwardAE), 32'(mon_e.fa));
      check("forwardBE", 32'(forwardBE), 32'(mon_e.fb));
      check("stallCount", stallCount, mon_e.cnt);
    end
  end

  initial begin
    vec_t v;
    // Reset with all inputs idle: every output low.
    v = nop(); v.rst = 1;
    drive(v); drive(v);
    drive(nop());

    // Load-use on rtD, then the same hazard with a taken branch.
    v = nop(); v.load = 1; v.rw_e = 1; v.w_e = 5; v.rt_d = 5;
    drive(v); drive(nop());
    v.br = 1; drive(v);
    v.br = 1; v.load = 0; drive(v);
    v = nop(); v.load = 1; v.rw_e = 1; v.w_e = 0; v.rs_d = 0; drive(v);

    // Multiply with no miss.
    v = nop(); v.mul = 1; drive(v);
    repeat (5) drive(nop());

    // Miss for three cycles, then data returns.
    v = nop(); v.miss = 1;
    repeat (3) drive(v);
    v.rdy = 1; drive(v);
    drive(nop());

    // Multiply whose completion collides with a miss.
    v = nop(); v.mul = 1; drive(v);
    repeat (3) drive(nop());
    v = nop(); v.miss = 1;
    repeat (2) drive(v);
    v.rdy = 1; drive(v);
    drive(nop());

    // Bypass priority and the zero-register exclusion.
    v = nop(); v.rs_e = 7; v.rt_e = 7; v.w_m = 7; v.w_w = 7; v.rw_m = 1; v.rw_w = 1;
    drive(v);
    v.rw_m = 0; drive(v);
    v = nop(); v.rw_m = 1; v.rw_w = 1; drive(v);
    v = nop(); v.rt_e = 3; v.w_w = 3; v.rw_w = 1; v.w_m = 4; v.rw_m = 1; drive(v);

    // Reset arriving mid-multiply with two stall cycles still owed.
    v = nop(); v.mul = 1; drive(v);
    drive(nop());
    v = nop(); v.rst = 1; drive(v);
    repeat (2) drive(nop());

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      v = nop();
      v.rst  = ($urandom_range(0, 199) == 0);
      v.rs_d = 5'($urandom_range(0, 7));
      v.rt_d = 5'($urandom_range(0, 7));
      v.rs_e = 5'($urandom_range(0, 7));
      v.rt_e = 5'($urandom_range(0, 7));
      v.w_e  = 5'($urandom_range(0, 7));
      v.w_m  = 5'($urandom_range(0, 7));
      v.w_w  = 5'($urandom_range(0, 7));
      v.rw_e = 1'($urandom_range(0, 1));
      v.rw_m = 1'($urandom_range(0, 1));
      v.rw_w = 1'($urandom_range(0, 1));
      v.load = ($urandom_range(0, 2) == 0);
      v.mul  = ($urandom_range(0, 9) == 0);
      v.br   = ($urandom_range(0, 3) == 0);
      if (m_in_miss) begin
        v.miss = ($urandom_range(0, 7) != 0);
        v.rdy  = ($urandom_range(0, 2) == 0);
      end else begin
        v.miss = ($urandom_range(0, 9) == 0);
        v.rdy  = ($urandom_range(0, 3) == 0);
      end
      drive(v);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MUL_LAT, 4, execute-stage multiply latency in cycles, legal range 1..15.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: rsD, rtD  input  5 each  source registers of the instruction in decode.
REQ-005 Port: rsE, rtE  input  5 each  source registers of the instruction in execute.
REQ-006 Port: writeRegE, writeRegM, writeRegW  input  5 each  destination registers in execute, memory and writeback.
REQ-007 Port: regWriteE, regWriteM, regWriteW  input  1 each  destination-write valid per stage.
REQ-008 Port: memToRegE  input  1  execute instruction is a load.
REQ-009 Port: mulStartE  input  1  execute instruction is a multiply.
REQ-010 Port: pcSrcD  input  1  taken branch or jump resolved in decode.
REQ-011 Port: dmissM, dreadyM  input  1 each  data-memory miss pending; miss data returned.
REQ-012 Port: stallF, stallD, stallE, stallM  output  1 each  hold PC and the F/D, D/E and E/M pipeline registers (register enable = ~stall).
REQ-013 Port: flushD, flushE  output  1 each  clear the F/D and D/E registers to a bubble.
REQ-014 Port: forwardAE, forwardBE  output  2 each  operand bypass select for SrcAE and SrcBE.
REQ-015 Port: mulDoneE  output  1  multiply result valid this cycle.
REQ-016 Port: busy  output  1  state is not RUN.
REQ-017 Port: stallCount  output  32  count of cycles with stallF=1.

Function
REQ-018 Define memWait = dmissM & ~dreadyM; define loadUse = memToRegE & regWriteE & (writeRegE!=0) & (writeRegE==rsD | writeRegE==rtD).
REQ-019 The FSM SHALL have three states: RUN, MUL_WAIT and MEM_WAIT, plus a 4-bit counter cnt.
REQ-020 In RUN with memWait, all four stalls SHALL be 1, flushE 0, and next state MEM_WAIT; mulStartE and loadUse are ignored that cycle.
REQ-021 In RUN with ~memWait and mulStartE, stallF/D/E SHALL be 1, stallM 0, cnt<=MUL_LAT-1, and next state MUL_WAIT; loadUse is ignored.
REQ-022 In RUN with neither condition, loadUse SHALL give stallF=stallD=flushE=1 for that cycle only, with the state unchanged.
REQ-023 In MUL_WAIT with cnt!=0: stallF/D/E=1, stallM=memWait, cnt decrements.
REQ-024 In MUL_WAIT with cnt==0 and ~memWait: all stalls 0, mulDoneE=1, next state RUN; with memWait: all stalls 1, hold state.
REQ-025 A multiply SHALL produce exactly MUL_LAT stall cycles of stallE with no miss, and mulDoneE SHALL be 1 in the following cycle.
REQ-026 In MEM_WAIT: all stalls SHALL be 1 while memWait; when dreadyM=1, stalls are 0 and next state is RUN.
REQ-027 flushD SHALL equal pcSrcD & ~stallD; flushE SHALL be 1 only per REQ-022.
REQ-028 forwardAE SHALL be 10 if regWriteM & writeRegM!=0 & writeRegM==rsE; else 01 if regWriteW & writeRegW!=0 & writeRegW==rsE; else 00. forwardBE is identical using rtE; the memory stage has priority.
REQ-029 stallCount SHALL increment on each edge with stallF=1 and saturate at 0xFFFFFFFF.
REQ-030 busy, stalls, flushes and mulDoneE SHALL be combinational from the state, cnt and inputs; stallCount, state and cnt are registered.

Reset
REQ-031 reset=1 SHALL immediately force state RUN, cnt 0 and stallCount 0, including mid-multiply or mid-miss; the in-flight operation is abandoned.
REQ-032 With reset asserted and all inputs 0, every output SHALL be 0.

Verification
REQ-033 Load r5 in E, decode uses rtD=5 -> one cycle of stallF=stallD=flushE=1; stallCount +1; next cycle clear.
REQ-034 mulStartE=1, MUL_LAT=4 -> stallE=1 for 4 cycles, mulDoneE=1 on the 5th with stalls 0, busy=1 for cycles 2-5.
REQ-035 dmissM=1 for 3 cycles, then dreadyM=1 -> all stalls 1 for 3 cycles, 0 on the dreadyM cycle, state returns to RUN.
REQ-036 Multiply with dmissM raised at cnt==0 -> mulDoneE withheld, all stalls 1 until dreadyM, then mulDoneE=1.
REQ-037 writeRegM=writeRegW=rsE=7, both regWrite=1 -> forwardAE=10; rsE=0 -> 00; pcSrcD during load-use stall -> flushD=0.
REQ-038 reset pulsed during MUL_WAIT cnt=2 -> busy=0 and stalls=0 immediately, stallCount=0.
